// File: rtl/rt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rt_pkg
// Description : Shared ray-tracing fixed-point constants, FSM state type and
//               hit-record type for the intersection back-end.
// Revision    : 1.0 - initial release
// ============================================================================
package rt_pkg;

    localparam int TRI_ID_W = 16;

    localparam logic signed [31:0] FIP_ONE = 32'sh00010000;
    localparam logic signed [31:0] FIP_MAX = 32'sh7fffffff;
    localparam logic signed [31:0] FIP_MIN = 32'sh80000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } chit_state_e;

    typedef struct packed {
        logic                hit;
        logic signed [31:0]  t;
        logic [TRI_ID_W-1:0] tri_id;
    } hit_rec_t;

endpackage
`default_nettype wire

// File: rtl/fip_nearer.sv
`default_nettype none
// ============================================================================
// Module      : fip_nearer
// Description : Combinational selector keeping the nearer of an incoming
//               intersection result and the current best hit record.
// Revision    : 1.0 - initial release
// ============================================================================
module fip_nearer
    import rt_pkg::*;
(
    input  logic                       i_result,
    input  logic signed [31:0]         i_t,
    input  logic [rt_pkg::TRI_ID_W-1:0] i_tri_id,
    input  hit_rec_t                   i_best,
    output hit_rec_t                   o_rec,
    output logic                       o_take
);

    // Strict less-than: on equal distance the record already held wins.
    assign o_take = i_result && (!i_best.hit || ($signed(i_t) < $signed(i_best.t)));

    always_comb begin
        o_rec = i_best;
        if (o_take) begin
            o_rec.hit    = 1'b1;
            o_rec.t      = i_t;
            o_rec.tri_id = i_tri_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/closest_hit_tracker.sv
`default_nettype none
// ============================================================================
// Module      : closest_hit_tracker
// Description : Per-ray reduction of the intersection stream to the nearest
//               hit, presented as one record on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module closest_hit_tracker #(
    parameter int TRI_ID_W = rt_pkg::TRI_ID_W,
    parameter int RAY_ID_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [TRI_ID_W-1:0] i_num_tris,
    input  logic [RAY_ID_W-1:0] i_ray_id,
    output logic                o_ready,
    input  logic                i_valid,
    input  logic [31:0]         i_t,
    input  logic                i_result,
    input  logic [TRI_ID_W-1:0] i_tri_id,
    output logic                o_valid,
    input  logic                i_out_ready,
    output logic                o_hit,
    output logic [31:0]         o_t,
    output logic [TRI_ID_W-1:0] o_tri_id,
    output logic [RAY_ID_W-1:0] o_ray_id,
    output logic                o_err
);

    // The record width follows the package; TRI_ID_W must match it.
    localparam rt_pkg::hit_rec_t c_miss_rec = '{hit: 1'b0, t: rt_pkg::FIP_MAX, tri_id: '0};

    rt_pkg::chit_state_e r_state;
    rt_pkg::chit_state_e w_state_next;
    logic [TRI_ID_W-1:0] r_remaining;
    logic [RAY_ID_W-1:0] r_ray_id;
    rt_pkg::hit_rec_t    r_best;
    rt_pkg::hit_rec_t    w_nearer;
    logic                w_take;
    logic                r_err;

    fip_nearer u_nearer (
        .i_result (i_result),
        .i_t      ($signed(i_t)),
        .i_tri_id (i_tri_id),
        .i_best   (r_best),
        .o_rec    (w_nearer),
        .o_take   (w_take)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= rt_pkg::IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            rt_pkg::IDLE: begin
                if (i_start) begin
                    w_state_next = (i_num_tris == '0) ? rt_pkg::DONE : rt_pkg::ACCUM;
                end
            end
            rt_pkg::ACCUM: begin
                if (i_valid && (r_remaining == TRI_ID_W'(1))) begin
                    w_state_next = rt_pkg::DONE;
                end
            end
            rt_pkg::DONE: begin
                if (i_out_ready) begin
                    w_state_next = rt_pkg::IDLE;
                end
            end
            default: w_state_next = rt_pkg::IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_remaining <= '0;
            r_ray_id    <= '0;
            r_best      <= c_miss_rec;
            r_err       <= 1'b0;
        end else begin
            if ((r_state == rt_pkg::IDLE) && i_start) begin
                r_remaining <= i_num_tris;
                r_ray_id    <= i_ray_id;
                r_best      <= c_miss_rec;
            end
            if ((r_state == rt_pkg::ACCUM) && i_valid) begin
                r_remaining <= r_remaining - TRI_ID_W'(1);
                r_best      <= w_nearer;
            end
            // Results outside ACCUM have nowhere to go; flag and drop them.
            if (i_valid && (r_state != rt_pkg::ACCUM)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_ready  = (r_state == rt_pkg::IDLE);
    assign o_valid  = (r_state == rt_pkg::DONE);
    assign o_hit    = r_best.hit;
    assign o_t      = r_best.t;
    assign o_tri_id = r_best.tri_id;
    assign o_ray_id = r_ray_id;
    assign o_err    = r_err;

endmodule
`default_nettype wire

// File: doc/closest_hit_tracker.md
# closest_hit_tracker

Per-ray reduction stage directly downstream of the pipelined ray/triangle intersection unit. It consumes the unit's per-triangle stream (t, hit flag, valid) for one ray and keeps the nearest valid hit and its triangle index. After the ray's declared triangle count has arrived, it presents a single closest-hit record on a valid/ready output to the shading stage.

## Interface
- TRI_ID_W, 16: triangle index width; also the width of the triangle-count input.
- RAY_ID_W, 16: ray tag width; the tag is passed through unchanged.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  begin a new ray; accepted only when o_ready=1.
- i_num_tris  in  TRI_ID_W  number of triangle results expected for this ray; sampled on accepted i_start.
- i_ray_id  in  RAY_ID_W  ray tag; sampled on accepted i_start.
- o_ready  out  1  high only in IDLE.
- i_valid  in  1  intersection result valid; connects to the intersection unit's o_valid.
- i_t  in  32  signed Q16.16 hit distance.
- i_result  in  1  hit flag from the intersection unit.
- i_tri_id  in  TRI_ID_W  index of the triangle that produced this result (arrival order is not assumed).
- o_valid  out  1  closest-hit record valid.
- i_out_ready  in  1  downstream accepts the record.
- o_hit  out  1  at least one hit was seen.
- o_t  out  32  nearest t; FIP_MAX when o_hit=0.
- o_tri_id  out  TRI_ID_W  triangle index of the nearest hit; 0 when o_hit=0.
- o_ray_id  out  RAY_ID_W  captured ray tag.
- o_err  out  1  sticky protocol error flag; cleared only by reset.

## Operation
- FSM states:
  - IDLE: o_ready=1. On i_start, capture i_num_tris into `remaining` and i_ray_id. Load best_t=FIP_MAX, best_id=0, best_hit=0. Go to ACCUM, or go directly to DONE if i_num_tris==0.
  - ACCUM: each cycle with i_valid=1:
    - Decrement `remaining`.
    - Update the best record when i_result=1 and (best_hit=0 or i_t < best_t). The comparison is signed 32-bit.
    - Ties are strictly-less: on equal t the earlier-arrived triangle is kept.
    - When the result consumed is the last one (remaining==1), go to DONE.
  - DONE: o_valid=1; outputs are driven from the registered best record and stay stable. On i_out_ready=1, go to IDLE.
- i_valid outside ACCUM (IDLE or DONE): the result is discarded and o_err is set. This includes i_valid arriving in the same cycle as i_start.
- i_start outside IDLE is ignored; o_err is not set, because o_ready is the qualifier.
- A hit with i_t equal to FIP_MAX still counts: o_hit=1, o_t=FIP_MAX.
- No arithmetic other than the compare and the TRI_ID_W-bit down-counter. The counter never wraps, because the transition to DONE occurs at 1.

## Timing
- Reset values:
  - o_ready=1 (FSM in IDLE)
  - o_valid=0, o_hit=0, o_t=FIP_MAX, o_tri_id=0, o_ray_id=0, o_err=0
- Reset asserted mid-ray abandons the ray; the next cycle is IDLE with all of the above values.
- Latency: o_valid rises on the cycle after the edge that consumes the last i_valid.
  - For i_num_tris==0: o_valid rises on the cycle after the i_start edge.
- Throughput: one result per cycle in ACCUM, with no stall toward upstream. There is no backpressure input to the intersection unit, so upstream must not issue the next ray's triangles before o_ready.
- Output handshake: transfer occurs on o_valid & i_out_ready. o_ready rises on the next cycle, so a new i_start is accepted at the earliest 1 cycle after transfer. There is no start/transfer overlap.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `rt_pkg` holds:
  - FIP_ONE (32'sh00010000), FIP_MAX (32'sh7fffffff), FIP_MIN (32'sh80000000)
  - typedef `chit_state_e` {IDLE, ACCUM, DONE}
  - packed struct `hit_rec_t` {hit, t, tri_id}, parameterised by width through the package localparam TRI_ID_W
- One natural sub-module: `fip_nearer`, a combinational strict signed-less-than selector between the incoming (i_result, i_t, i_tri_id) and the best record. It is reusable by a future BVH leaf reducer.
- Everything else is inline: FSM, counter, record registers.

## Test plan
- Start, num_tris=3, ray_id=5; results (hit, t=0x00030000, id 7), (hit, t=0x00018000, id 2), (miss, t=0x00008000, id 9) -> one cycle later o_valid=1, o_hit=1, o_t=0x00018000, o_tri_id=2, o_ray_id=5.
- num_tris=2, both misses -> o_hit=0, o_t=0x7fffffff, o_tri_id=0. Also num_tris=0 -> o_valid one cycle after start with the same miss record.
- Tie: hits id 4 and id 6, both t=0x00020000 -> o_tri_id=4. Negative t: hit t=0xffff0000 (id 1) versus t=0x00010000 (id 3) -> o_tri_id=1 (signed compare).
- Hold i_out_ready=0 for 5 cycles in DONE while driving i_valid -> outputs unchanged, o_err=1 and stays 1. Then i_out_ready=1 -> o_ready=1 on the next cycle.
- Back-to-back stream: num_tris=4 with i_valid high 4 consecutive cycles -> exactly one o_valid; a 5th i_valid sets o_err. Then a second ray is accepted and o_err stays 1.
- Assert i_rst after 2 of 4 results -> next cycle all outputs equal their reset values. A new start then produces correct results with no carry-over of the best record.
